// File: rtl/lc3_mem_access_if.sv
// Pipeline-side and memory-side handshake bundle for lc3_mem_access.
// master = the access unit itself, slave = pipeline stages plus memory model.
interface lc3_mem_access_if;
    logic        fetch_req;
    logic [15:0] fetch_pc;
    logic        fetch_done;
    logic [15:0] fetch_instr;

    logic        mem_req;
    logic        mem_we;
    logic        mem_indirect;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic        mem_busy;
    logic        mem_err;

    logic        instrmem_rd;
    logic [15:0] pc;
    logic [15:0] Instr_dout;
    logic        complete_instr;

    logic        Data_en;
    logic        Data_rd;
    logic [15:0] Data_addr;
    logic [15:0] Data_din;
    logic [15:0] Data_dout;
    logic        complete_data;

    modport master (
        input  fetch_req, fetch_pc, mem_req, mem_we, mem_indirect, mem_addr, mem_wdata,
               Instr_dout, complete_instr, Data_dout, complete_data,
        output fetch_done, fetch_instr, mem_done, mem_rdata, mem_busy, mem_err,
               instrmem_rd, pc, Data_en, Data_rd, Data_addr, Data_din
    );

    modport slave (
        output fetch_req, fetch_pc, mem_req, mem_we, mem_indirect, mem_addr, mem_wdata,
               Instr_dout, complete_instr, Data_dout, complete_data,
        input  fetch_done, fetch_instr, mem_done, mem_rdata, mem_busy, mem_err,
               instrmem_rd, pc, Data_en, Data_rd, Data_addr, Data_din
    );
endinterface

// File: rtl/lc3_mem_access.sv
// LC3 memory initiator: instruction fetch channel plus data channel with LDI/STI pointer sequencing.
// Define LC3_MEM_TIMEOUT_EN to abort accesses whose complete_* does not arrive within TIMEOUT cycles.
module lc3_mem_access #(
    parameter logic [15:0] BASE_ADDR = 16'h3000,
    parameter int unsigned TIMEOUT   = 15
) (
    input logic              clk,
    input logic              reset,
    lc3_mem_access_if.master bus
);
    typedef enum logic {F_IDLE, F_WAIT} fstate_t;
    typedef enum logic [2:0] {IDLE, PTR, RD, WR, DONE} dstate_t;

    // The wait counters are 4 bits wide.
    if (TIMEOUT == 0 || TIMEOUT > 15) begin : g_timeout_range
        $error("lc3_mem_access: TIMEOUT must be in 1..15");
    end

    fstate_t     fstate_q, fstate_d;
    logic [15:0] pc_q, pc_d;
    logic        instrmem_rd_q, instrmem_rd_d;
    logic        fetch_done_q, fetch_done_d;
    logic [15:0] fetch_instr_q, fetch_instr_d;

    dstate_t     dstate_q, dstate_d;
    logic        data_en_q, data_en_d;
    logic        data_rd_q, data_rd_d;
    logic [15:0] data_addr_q, data_addr_d;
    logic [15:0] data_din_q, data_din_d;
    logic        mem_done_q, mem_done_d;
    logic [15:0] mem_rdata_q, mem_rdata_d;
    logic        mem_busy_q, mem_busy_d;
    logic        store_q, store_d;

`ifdef LC3_MEM_TIMEOUT_EN
    localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);
    logic [3:0] ftmr_q, ftmr_d;
    logic [3:0] dtmr_q, dtmr_d;
    logic       mem_err_q, mem_err_d;
`endif

    always_comb begin
        fstate_d      = fstate_q;
        pc_d          = pc_q;
        instrmem_rd_d = instrmem_rd_q;
        fetch_done_d  = 1'b0;
        fetch_instr_d = fetch_instr_q;
`ifdef LC3_MEM_TIMEOUT_EN
        ftmr_d        = '0;
`endif
        case (fstate_q)
            F_IDLE: begin
                if (bus.fetch_req) begin
                    pc_d          = bus.fetch_pc;
                    instrmem_rd_d = 1'b1;
                    fstate_d      = F_WAIT;
                end
            end
            F_WAIT: begin
                if (bus.complete_instr) begin
                    fetch_instr_d = bus.Instr_dout;
                    fetch_done_d  = 1'b1;
                    instrmem_rd_d = 1'b0;
                    fstate_d      = F_IDLE;
                end
`ifdef LC3_MEM_TIMEOUT_EN
                else if (ftmr_q == TMO_LAST) begin
                    instrmem_rd_d = 1'b0;
                    fstate_d      = F_IDLE;
                end else begin
                    ftmr_d = ftmr_q + 4'd1;
                end
`endif
            end
            default: fstate_d = F_IDLE;
        endcase
    end

    // The store flag is kept so the pointer phase knows whether to continue with RD or WR.
    always_comb begin
        dstate_d    = dstate_q;
        data_en_d   = data_en_q;
        data_rd_d   = data_rd_q;
        data_addr_d = data_addr_q;
        data_din_d  = data_din_q;
        mem_done_d  = 1'b0;
        mem_rdata_d = mem_rdata_q;
        mem_busy_d  = mem_busy_q;
        store_d     = store_q;
`ifdef LC3_MEM_TIMEOUT_EN
        dtmr_d      = '0;
        mem_err_d   = 1'b0;
`endif
        case (dstate_q)
            IDLE: begin
                if (bus.mem_req) begin
                    data_addr_d = bus.mem_addr;
                    store_d     = bus.mem_we;
                    data_en_d   = 1'b1;
                    mem_busy_d  = 1'b1;
                    if (bus.mem_we) data_din_d = bus.mem_wdata;
                    if (bus.mem_indirect) begin
                        data_rd_d = 1'b1;
                        dstate_d  = PTR;
                    end else if (bus.mem_we) begin
                        data_rd_d = 1'b0;
                        dstate_d  = WR;
                    end else begin
                        data_rd_d = 1'b1;
                        dstate_d  = RD;
                    end
                end
            end
            PTR, RD, WR: begin
                if (bus.complete_data) begin
                    if (dstate_q == PTR) begin
                        data_addr_d = bus.Data_dout;
                        data_rd_d   = !store_q;
                        dstate_d    = store_q ? WR : RD;
                    end else begin
                        if (dstate_q == RD) mem_rdata_d = bus.Data_dout;
                        data_en_d = 1'b0;
                        data_rd_d = 1'b0;
                        dstate_d  = DONE;
                    end
                end
`ifdef LC3_MEM_TIMEOUT_EN
                else if (dtmr_q == TMO_LAST) begin
                    data_en_d  = 1'b0;
                    data_rd_d  = 1'b0;
                    mem_busy_d = 1'b0;
                    mem_err_d  = 1'b1;
                    dstate_d   = IDLE;
                end else begin
                    dtmr_d = dtmr_q + 4'd1;
                end
`endif
            end
            DONE: begin
                mem_done_d = 1'b1;
                mem_busy_d = 1'b0;
                dstate_d   = IDLE;
            end
            default: dstate_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fstate_q      <= F_IDLE;
            pc_q          <= BASE_ADDR;
            instrmem_rd_q <= 1'b0;
            fetch_done_q  <= 1'b0;
            fetch_instr_q <= '0;
            dstate_q      <= IDLE;
            data_en_q     <= 1'b0;
            data_rd_q     <= 1'b0;
            data_addr_q   <= '0;
            data_din_q    <= '0;
            mem_done_q    <= 1'b0;
            mem_rdata_q   <= '0;
            mem_busy_q    <= 1'b0;
            store_q       <= 1'b0;
`ifdef LC3_MEM_TIMEOUT_EN
            ftmr_q        <= '0;
            dtmr_q        <= '0;
            mem_err_q     <= 1'b0;
`endif
        end else begin
            fstate_q      <= fstate_d;
            pc_q          <= pc_d;
            instrmem_rd_q <= instrmem_rd_d;
            fetch_done_q  <= fetch_done_d;
            fetch_instr_q <= fetch_instr_d;
            dstate_q      <= dstate_d;
            data_en_q     <= data_en_d;
            data_rd_q     <= data_rd_d;
            data_addr_q   <= data_addr_d;
            data_din_q    <= data_din_d;
            mem_done_q    <= mem_done_d;
            mem_rdata_q   <= mem_rdata_d;
            mem_busy_q    <= mem_busy_d;
            store_q       <= store_d;
`ifdef LC3_MEM_TIMEOUT_EN
            ftmr_q        <= ftmr_d;
            dtmr_q        <= dtmr_d;
            mem_err_q     <= mem_err_d;
`endif
        end
    end

    assign bus.pc          = pc_q;
    assign bus.instrmem_rd = instrmem_rd_q;
    assign bus.fetch_done  = fetch_done_q;
    assign bus.fetch_instr = fetch_instr_q;
    assign bus.Data_en     = data_en_q;
    assign bus.Data_rd     = data_rd_q;
    assign bus.Data_addr   = data_addr_q;
    assign bus.Data_din    = data_din_q;
    assign bus.mem_done    = mem_done_q;
    assign bus.mem_rdata   = mem_rdata_q;
    assign bus.mem_busy    = mem_busy_q;
`ifdef LC3_MEM_TIMEOUT_EN
    assign bus.mem_err     = mem_err_q;
`else
    assign bus.mem_err     = 1'b0;
`endif
endmodule

// File: tb/tb_lc3_mem_access.sv
// Directed bench for lc3_mem_access: fetch, LD, STI, back-to-back, concurrency and reset-abort.
module tb_lc3_mem_access;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    lc3_mem_access_if bus ();

    lc3_mem_access #(.BASE_ADDR(16'h3000), .TIMEOUT(15)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.fetch_req = 1'b0; bus.fetch_pc = '0;
        bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_indirect = 1'b0;
        bus.mem_addr = '0; bus.mem_wdata = '0;
        bus.Instr_dout = '0; bus.complete_instr = 1'b0;
        bus.Data_dout = '0; bus.complete_data = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] strobes;
        reset = 1'b0;
        idle_inputs();
        tick();
        tick();
        strobes = {bus.instrmem_rd, bus.fetch_done, bus.mem_done, bus.Data_en, bus.Data_rd, bus.mem_busy, bus.mem_err};
        n_checks++; if (bus.pc !== 16'h3000) begin n_fail++; $display("FAIL reset_pc: got %h expected 3000", bus.pc); end
        n_checks++; if (strobes !== 7'b0) begin n_fail++; $display("FAIL reset_strobes: got %b expected 0000000", strobes); end
        n_checks++; if ({bus.fetch_instr, bus.mem_rdata, bus.Data_addr, bus.Data_din} !== 64'h0) begin n_fail++;
            $display("FAIL reset_data: got %h %h %h %h expected all 0", bus.fetch_instr, bus.mem_rdata, bus.Data_addr, bus.Data_din); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        bus.fetch_req = 1'b1; bus.fetch_pc = 16'h3000;
        tick();
        n_checks++; if ({bus.instrmem_rd, bus.fetch_done} !== 2'b10) begin n_fail++; $display("FAIL fetch_strobe: got %b expected 10", {bus.instrmem_rd, bus.fetch_done}); end
        bus.fetch_req = 1'b0;
        bus.complete_instr = 1'b1; bus.Instr_dout = 16'h1261;
        tick();
        bus.complete_instr = 1'b0; bus.Instr_dout = 16'hFFFF;
        n_checks++; if ({bus.fetch_done, bus.instrmem_rd} !== 2'b10) begin n_fail++; $display("FAIL fetch_done: got %b expected 10", {bus.fetch_done, bus.instrmem_rd}); end
        n_checks++; if (bus.fetch_instr !== 16'h1261) begin n_fail++; $display("FAIL fetch_instr: got %h expected 1261", bus.fetch_instr); end
        tick();
        n_checks++; if ({bus.fetch_done, bus.fetch_instr} !== {1'b0, 16'h1261}) begin n_fail++;
            $display("FAIL fetch_hold: got done=%b instr=%h expected done=0 instr=1261", bus.fetch_done, bus.fetch_instr); end
    endtask

    task automatic test_ld();
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_indirect = 1'b0; bus.mem_addr = 16'h3010;
        tick();
        n_checks++; if ({bus.Data_en, bus.Data_rd, bus.mem_busy, bus.Data_addr} !== {3'b111, 16'h3010}) begin n_fail++;
            $display("FAIL ld_issue: got en/rd/busy=%b%b%b addr=%h expected 111 3010", bus.Data_en, bus.Data_rd, bus.mem_busy, bus.Data_addr); end
        bus.mem_req = 1'b0;
        bus.complete_data = 1'b1; bus.Data_dout = 16'hABCD;
        tick();
        bus.complete_data = 1'b0; bus.Data_dout = 16'h0000;
        n_checks++; if ({bus.Data_en, bus.mem_done} !== 2'b00) begin n_fail++; $display("FAIL ld_done_state: got en/done=%b expected 00", {bus.Data_en, bus.mem_done}); end
        tick();
        n_checks++; if ({bus.mem_done, bus.mem_busy} !== 2'b10) begin n_fail++; $display("FAIL ld_mem_done: got done/busy=%b expected 10", {bus.mem_done, bus.mem_busy}); end
        n_checks++; if (bus.mem_rdata !== 16'hABCD) begin n_fail++; $display("FAIL ld_rdata: got %h expected abcd", bus.mem_rdata); end
        tick();
        n_checks++; if (bus.mem_done !== 1'b0) begin n_fail++; $display("FAIL ld_done_pulse: got %b expected 0", bus.mem_done); end
    endtask

    task automatic test_sti();
        bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_indirect = 1'b1;
        bus.mem_addr = 16'h3020; bus.mem_wdata = 16'h5555;
        tick();
        bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_indirect = 1'b0;
        n_checks++; if ({bus.Data_en, bus.Data_rd, bus.Data_addr} !== {2'b11, 16'h3020}) begin n_fail++;
            $display("FAIL sti_ptr: got en/rd=%b%b addr=%h expected 11 3020", bus.Data_en, bus.Data_rd, bus.Data_addr); end
        tick();
        n_checks++; if ({bus.Data_en, bus.Data_rd, bus.Data_addr} !== {2'b11, 16'h3020}) begin n_fail++;
            $display("FAIL sti_ptr_wait: got en/rd=%b%b addr=%h expected 11 3020", bus.Data_en, bus.Data_rd, bus.Data_addr); end
        bus.complete_data = 1'b1; bus.Data_dout = 16'h4000;
        tick();
        n_checks++; if ({bus.Data_en, bus.Data_rd, bus.Data_addr, bus.Data_din} !== {2'b10, 16'h4000, 16'h5555}) begin n_fail++;
            $display("FAIL sti_write: got en/rd=%b%b addr=%h din=%h expected 10 4000 5555", bus.Data_en, bus.Data_rd, bus.Data_addr, bus.Data_din); end
        bus.Data_dout = 16'h1234;
        tick();
        bus.complete_data = 1'b0;
        n_checks++; if ({bus.Data_en, bus.mem_done, bus.mem_rdata} !== {2'b00, 16'hABCD}) begin n_fail++;
            $display("FAIL sti_done_state: got en/done=%b%b rdata=%h expected 00 abcd", bus.Data_en, bus.mem_done, bus.mem_rdata); end
        tick();
        n_checks++; if (bus.mem_done !== 1'b1) begin n_fail++; $display("FAIL sti_mem_done: got %b expected 1", bus.mem_done); end
        bus.complete_data = 1'b1; bus.Data_dout = 16'hFFFF;
        tick();
        bus.complete_data = 1'b0;
        n_checks++; if ({bus.Data_en, bus.mem_busy, bus.mem_rdata} !== {2'b00, 16'hABCD}) begin n_fail++;
            $display("FAIL idle_ignores_complete: got en/busy=%b%b rdata=%h expected 00 abcd", bus.Data_en, bus.mem_busy, bus.mem_rdata); end
    endtask

    task automatic test_back_to_back();
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_indirect = 1'b1; bus.mem_addr = 16'h3030;
        tick();
        bus.mem_we = 1'b1; bus.mem_indirect = 1'b0; bus.mem_addr = 16'h0042; bus.mem_wdata = 16'h00AA;
        bus.complete_data = 1'b1; bus.Data_dout = 16'hFFFF;
        tick();
        n_checks++; if ({bus.Data_rd, bus.Data_addr} !== {1'b1, 16'hFFFF}) begin n_fail++;
            $display("FAIL ldi_ptr_ffff: got rd=%b addr=%h expected 1 ffff", bus.Data_rd, bus.Data_addr); end
        bus.Data_dout = 16'h7777;
        tick();
        bus.complete_data = 1'b0;
        n_checks++; if ({bus.Data_en, bus.mem_rdata} !== {1'b0, 16'h7777}) begin n_fail++;
            $display("FAIL ldi_rdata: got en=%b rdata=%h expected 0 7777", bus.Data_en, bus.mem_rdata); end
        tick();
        n_checks++; if ({bus.mem_done, bus.Data_en} !== 2'b10) begin n_fail++; $display("FAIL b2b_gap: got done/en=%b expected 10", {bus.mem_done, bus.Data_en}); end
        tick();
        bus.mem_req = 1'b0; bus.mem_we = 1'b0;
        n_checks++; if ({bus.Data_en, bus.Data_rd, bus.Data_addr, bus.Data_din} !== {2'b10, 16'h0042, 16'h00AA}) begin n_fail++;
            $display("FAIL b2b_st: got en/rd=%b%b addr=%h din=%h expected 10 0042 00aa", bus.Data_en, bus.Data_rd, bus.Data_addr, bus.Data_din); end
        bus.complete_data = 1'b1;
        tick();
        bus.complete_data = 1'b0;
        tick();
        n_checks++; if ({bus.mem_done, bus.mem_rdata} !== {1'b1, 16'h7777}) begin n_fail++;
            $display("FAIL b2b_st_done: got done=%b rdata=%h expected 1 7777", bus.mem_done, bus.mem_rdata); end
        tick();
    endtask

    task automatic test_concurrency();
        bus.fetch_req = 1'b1; bus.fetch_pc = 16'h3100;
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_indirect = 1'b0; bus.mem_addr = 16'h3040;
        tick();
        bus.mem_req = 1'b0; bus.mem_addr = 16'h0BAD; bus.fetch_pc = 16'hDEAD;
        tick();
        tick();
        n_checks++; if ({bus.pc, bus.Data_addr, bus.instrmem_rd, bus.Data_en} !== {16'h3100, 16'h3040, 2'b11}) begin n_fail++;
            $display("FAIL conc_wait: got pc=%h addr=%h ird=%b en=%b expected 3100 3040 1 1", bus.pc, bus.Data_addr, bus.instrmem_rd, bus.Data_en); end
        bus.fetch_req = 1'b0;
        bus.complete_instr = 1'b1; bus.Instr_dout = 16'h5A5A;
        bus.complete_data = 1'b1; bus.Data_dout = 16'h0F0F;
        tick();
        bus.complete_instr = 1'b0; bus.complete_data = 1'b0;
        n_checks++; if ({bus.fetch_done, bus.fetch_instr, bus.mem_rdata} !== {1'b1, 16'h5A5A, 16'h0F0F}) begin n_fail++;
            $display("FAIL conc_done: got fdone=%b instr=%h rdata=%h expected 1 5a5a 0f0f", bus.fetch_done, bus.fetch_instr, bus.mem_rdata); end
        tick();
        n_checks++; if ({bus.mem_done, bus.fetch_done, bus.pc} !== {2'b10, 16'h3100}) begin n_fail++;
            $display("FAIL conc_mem_done: got mdone=%b fdone=%b pc=%h expected 1 0 3100", bus.mem_done, bus.fetch_done, bus.pc); end
    endtask

    task automatic test_reset_mid_access();
        logic seen;
        bus.fetch_req = 1'b1; bus.fetch_pc = 16'h3200;
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_indirect = 1'b1; bus.mem_addr = 16'h3050;
        tick();
        idle_inputs();
        n_checks++; if ({bus.pc, bus.Data_en} !== {16'h3200, 1'b1}) begin n_fail++;
            $display("FAIL rst_pre: got pc=%h en=%b expected 3200 1", bus.pc, bus.Data_en); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if ({bus.pc, bus.Data_addr, bus.mem_rdata, bus.fetch_instr} !== {16'h3000, 48'h0}) begin n_fail++;
            $display("FAIL rst_async_data: got pc=%h addr=%h rdata=%h instr=%h expected 3000 0 0 0", bus.pc, bus.Data_addr, bus.mem_rdata, bus.fetch_instr); end
        n_checks++; if ({bus.Data_en, bus.Data_rd, bus.mem_busy, bus.instrmem_rd} !== 4'b0) begin n_fail++;
            $display("FAIL rst_async_strobes: got %b expected 0000", {bus.Data_en, bus.Data_rd, bus.mem_busy, bus.instrmem_rd}); end
        bus.complete_data = 1'b1; bus.Data_dout = 16'h1111;
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.complete_data = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | bus.mem_done | bus.Data_en;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_no_done: got %b expected 0", seen); end
        bus.mem_req = 1'b1; bus.mem_addr = 16'h3010;
        tick();
        bus.mem_req = 1'b0;
        bus.complete_data = 1'b1; bus.Data_dout = 16'hABCD;
        tick();
        bus.complete_data = 1'b0;
        tick();
        n_checks++; if ({bus.mem_done, bus.mem_rdata} !== {1'b1, 16'hABCD}) begin n_fail++;
            $display("FAIL rst_then_ld: got done=%b rdata=%h expected 1 abcd", bus.mem_done, bus.mem_rdata); end
        tick();
    endtask

`ifdef LC3_MEM_TIMEOUT_EN
    task automatic test_timeout();
        logic early;
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_indirect = 1'b0; bus.mem_addr = 16'h3060;
        tick();
        bus.mem_req = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            early = early | bus.mem_err | !bus.mem_busy;
        end
        n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b expected 0", early); end
        tick();
        n_checks++; if ({bus.mem_err, bus.mem_busy, bus.mem_done, bus.Data_en, bus.mem_rdata} !== {4'b1000, 16'hABCD}) begin n_fail++;
            $display("FAIL tmo_abort: got err/busy/done/en=%b rdata=%h expected 1000 abcd", {bus.mem_err, bus.mem_busy, bus.mem_done, bus.Data_en}, bus.mem_rdata); end
        tick();
        n_checks++; if ({bus.mem_err, bus.mem_busy} !== 2'b00) begin n_fail++; $display("FAIL tmo_pulse: got %b expected 00", {bus.mem_err, bus.mem_busy}); end
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_ld();
        test_sti();
        test_back_to_back();
        test_concurrency();
        test_reset_mid_access();
`ifdef LC3_MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
